// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Holds a 16-bit hex value plus four decimal-point bits and steps a 2-bit
//   digit select every REFRESH_DIV clocks. It drives the active-low segment
//   pattern and decimal point for the selected digit. Loads go into a shadow
//   buffer and are committed to the display only on the 3->0 select wrap,
//   so a frame is never torn.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   value[15:0]  hex value; nibble k -> digit k (digit 0 is rightmost)
//   dp_in[3:0]   decimal-point request per digit, 1 = lit
//   load         strobe: capture value/dp_in into the shadow buffer
//   digit_en[3:0] live per-digit enable, 0 blanks segments and dp
//   sel[1:0]     active digit, to the anode decoder
//   seg[6:0]     active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   frame_start  one-cycle pulse on the edge where sel wraps 3->0
//
// Build option
//   SEG_SCAN_LZB_EN  when defined, digits 3..1 are blanked while they and
//                    every more-significant nibble of the display are zero.

module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [1:0]  sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  digit_t          state, state_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt;
  logic            tick;
  logic            wrap;
  logic            commit;

  logic [15:0]     sh_val;
  logic [3:0]      sh_dp;
  logic            pending;
  logic [15:0]     d_val, d_val_nxt;
  logic [3:0]      d_dp, d_dp_nxt;

  logic [1:0]      idx;
  logic [3:0]      nib;
  logic            lz_blank;
  logic [6:0]      seg_nxt;
  logic            dp_nxt;
  logic            fs_nxt;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      default: f = 7'b0001110;
    endcase
    return f;
  endfunction

  // State register: digit slot and prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIG0;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    tick      = (pcnt == PLAST);
    pcnt_nxt  = tick ? '0 : pcnt + PW'(1);
    state_nxt = state;
    if (tick) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        default: state_nxt = DIG0;
      endcase
    end
    wrap = tick && (state == DIG3);
  end

  // Double buffer. The commit reads the shadow as it was before this edge,
  // so a load landing on the wrap edge stays pending for the next frame.
  assign commit    = wrap & pending;
  assign d_val_nxt = commit ? sh_val : d_val;
  assign d_dp_nxt  = commit ? sh_dp  : d_dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      pending <= 1'b0;
      d_val   <= '0;
      d_dp    <= '0;
    end else begin
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
      pending <= load | (pending & ~wrap);
      d_val   <= d_val_nxt;
      d_dp    <= d_dp_nxt;
    end
  end

  // Output logic. Evaluated against the next slot and next display data so
  // the registered seg/dp line up with sel in the same cycle, including the
  // digit-0 slot that opens right on a commit.
  always_comb begin
    idx = state_nxt;
    nib = d_val_nxt[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
    case (idx)
      2'd1:    lz_blank = (d_val_nxt[15:4]  == '0);
      2'd2:    lz_blank = (d_val_nxt[15:8]  == '0);
      2'd3:    lz_blank = (d_val_nxt[15:12] == '0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    if (!digit_en[idx]) begin
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
    end else if (lz_blank) begin
      seg_nxt = SEG_OFF;
      dp_nxt  = ~d_dp_nxt[idx];
    end else begin
      seg_nxt = font(nib);
      dp_nxt  = ~d_dp_nxt[idx];
    end

    fs_nxt = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg         <= SEG_ZERO;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= fs_nxt;
    end
  end

  assign sel = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with REFRESH_DIV = 4. A time-based model
// (cycle count since reset -> slot and wrap) predicts every output each
// cycle. Directed sections pin known patterns with literal values, and a
// randomized phase follows them.

module tb_seg_scan_ctrl;

  localparam int unsigned R = 4;
  localparam int unsigned FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'b1111;
  logic [1:0]  sel;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.REFRESH_DIV(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .digit_en    (digit_en),
    .sel         (sel),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned mn = 0;
  bit          m_valid = 0;
  bit          m_pend;
  logic [15:0] m_sh, m_d;
  logic [3:0]  m_shdp, m_ddp;
  logic [1:0]  e_sel;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;

  always @(posedge clk) begin
    if (reset) begin
      mn = 0; m_valid = 1; m_pend = 0;
      m_sh = '0; m_d = '0; m_shdp = '0; m_ddp = '0;
      e_sel = 2'd0; e_seg = 7'b1000000; e_dp = 1'b1; e_fs = 1'b0;
    end else if (m_valid) begin
      int unsigned k;
      bit wrap, blank;
      logic [15:0] upper;
      mn++;
      wrap = (mn % FRAME) == 0;
      if (wrap && m_pend) begin
        m_d = m_sh; m_ddp = m_shdp; m_pend = 0;
      end
      if (load) begin
        m_sh = value; m_shdp = dp_in; m_pend = 1;
      end
      k = (mn / R) % 4;
      e_sel = 2'(k);
      e_fs  = wrap;
      upper = m_d >> (4 * k);
      blank = 0;
`ifdef SEG_SCAN_LZB_EN
      blank = (k > 0) && (upper == 16'h0000);
`endif
      if (!digit_en[k]) begin
        e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_seg = blank ? 7'b1111111 : FONT[upper[3:0]];
        e_dp  = ~m_ddp[k];
      end
    end
    #2;
    if (m_valid) begin
      check("sel", 32'(sel), 32'(e_sel));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_frame();
    int i = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (frame_start !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frame: no frame_start within 100 cycles");
    end
  endtask

  task automatic pin_digit(input string name, input logic [1:0] k,
                           input logic [6:0] es, input logic edp);
    for (int i = 0; i < 64 && sel !== k; i++) @(negedge clk);
    if (sel !== k) begin
      n_checks++; n_fail++;
      $display("FAIL %s: sel never reached %0d", name, k);
    end else begin
      check({name, "_seg"}, 32'(seg), 32'(es));
      check({name, "_dp"}, 32'(dp), 32'(edp));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] seq [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    int cnt;
    bit saw5;

    // Reset / scan
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge clk); cnt++; end
      check("scan_seq", 32'(sel), 32'(seq[i]));
    end
    while (frame_start !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    check("fs_first_gap", cnt, 16);
    check("fs_sel0", 32'(sel), 32'd0);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_start !== 1'b1 && cnt < 100);
    check("fs_period", cnt, 16);

    // Load / commit mid-frame
    repeat (5) @(negedge clk);
    do_load(16'h12AF, 4'b0100);
    wait_frame();
    pin_digit("lc_d0", 2'd0, 7'b0001110, 1'b1);
    pin_digit("lc_d1", 2'd1, 7'b0001000, 1'b1);
    pin_digit("lc_d2", 2'd2, 7'b0100100, 1'b0);
    pin_digit("lc_d3", 2'd3, 7'b1111001, 1'b1);

    // Wrap collision
    wait_frame();
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    for (int i = 0; i < 40 && ((mn + 1) % FRAME) != 0; i++) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    check("wc_fs", 32'(frame_start), 32'd1);
    check("wc_first_seg", 32'(seg), 32'(7'b1111001));
    pin_digit("wc_f1_d3", 2'd3, 7'b1111001, 1'b1);
    wait_frame();
    pin_digit("wc_f2_d0", 2'd0, 7'b0100100, 1'b1);
    pin_digit("wc_f2_d3", 2'd3, 7'b0100100, 1'b1);

    // Enable
    digit_en = 4'b1010;
    repeat (2) @(negedge clk);
    do_load(16'h8888, 4'b1111);
    wait_frame();
    pin_digit("en_d0", 2'd0, 7'b1111111, 1'b1);
    pin_digit("en_d1", 2'd1, 7'b0000000, 1'b0);
    pin_digit("en_d2", 2'd2, 7'b1111111, 1'b1);
    pin_digit("en_d3", 2'd3, 7'b0000000, 1'b0);
    digit_en = 4'b1111;

    // Leading-zero blanking
    repeat (2) @(negedge clk);
    do_load(16'h0040, 4'b1000);
    wait_frame();
    pin_digit("lz_d0", 2'd0, 7'b1000000, 1'b1);
    pin_digit("lz_d1", 2'd1, 7'b0011001, 1'b1);
`ifdef SEG_SCAN_LZB_EN
    pin_digit("lz_d2", 2'd2, 7'b1111111, 1'b1);
    pin_digit("lz_d3", 2'd3, 7'b1111111, 1'b0);
`else
    pin_digit("lz_d2", 2'd2, 7'b1000000, 1'b1);
    pin_digit("lz_d3", 2'd3, 7'b1000000, 1'b0);
`endif

    // Reset mid-frame with a pending load
    wait_frame();
    repeat (3) @(negedge clk);
    do_load(16'h5555, 4'b1111);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_sel", 32'(sel), 32'd0);
    check("mr_seg", 32'(seg), 32'(7'b1000000));
    check("mr_dp", 32'(dp), 32'd1);
    check("mr_fs", 32'(frame_start), 32'd0);
    reset = 1'b0;
    saw5 = 0;
    repeat (40) begin
      @(negedge clk);
      if (seg === 7'b0010010 || dp === 1'b0) saw5 = 1;
    end
    check("mr_discarded", 32'(saw5), 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    load = 1'b0; reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
